// File: rtl/alu_issue_ctrl_pkg.sv
// Shared encodings for the ALU issue controller: op codes, control classes,
// func7 patterns and FSM states.
package alu_issue_ctrl_pkg;

    localparam int unsigned OP_CODE_W = 2;
    localparam int unsigned CTRL_W    = 2;
    localparam int unsigned FUNC7_W   = 7;

    localparam logic [OP_CODE_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_CODE_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_CODE_W-1:0] OP_MUL = 2'b10;

    localparam logic [CTRL_W-1:0] CTRL_LDST   = 2'b00;
    localparam logic [CTRL_W-1:0] CTRL_BRANCH = 2'b01;
    localparam logic [CTRL_W-1:0] CTRL_RTYPE  = 2'b10;
    localparam logic [CTRL_W-1:0] CTRL_JUMP   = 2'b11;

    localparam logic [FUNC7_W-1:0] F7_ADD = 7'b0000000;
    localparam logic [FUNC7_W-1:0] F7_SUB = 7'b0100000;
    localparam logic [FUNC7_W-1:0] F7_MUL = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_VALID    = 2'b01,
        ST_MUL_WAIT = 2'b10
    } state_t;

    typedef struct packed {
        logic [OP_CODE_W-1:0] op;
        logic                 illegal;
    } dec_t;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Decode-to-execute handshake bundle for the ALU issue controller.
interface alu_issue_ctrl_if #(
    parameter int unsigned ALU_OP_WIDTH = 2
) ();
    logic                    in_valid;
    logic                    in_ready;
    logic [6:0]              inst;
    logic [1:0]              ctrl_alu_op;
    logic                    out_valid;
    logic                    out_ready;
    logic [ALU_OP_WIDTH-1:0] alu_op;
    logic                    illegal;
    logic                    mul_busy;

    modport master (
        output in_valid, inst, ctrl_alu_op, out_ready,
        input  in_ready, out_valid, alu_op, illegal, mul_busy
    );

    modport slave (
        input  in_valid, inst, ctrl_alu_op, out_ready,
        output in_ready, out_valid, alu_op, illegal, mul_busy
    );
endinterface

// File: rtl/alu_issue_ctrl_alu_op_decode.sv
// Purely combinational func7/op-class to ALU op decode, shared with ALUControl.
module alu_op_decode
    import alu_issue_ctrl_pkg::*;
(
    input  logic [FUNC7_W-1:0] i_func7,
    input  logic [CTRL_W-1:0]  i_ctrl,
    output dec_t               o_dec_c
);

    always_comb begin
        o_dec_c.op      = OP_ADD;
        o_dec_c.illegal = 1'b0;
        case (i_ctrl)
            CTRL_BRANCH: o_dec_c.op = OP_SUB;
            CTRL_RTYPE: begin
                case (i_func7)
                    F7_ADD:  o_dec_c.op = OP_ADD;
                    F7_SUB:  o_dec_c.op = OP_SUB;
                    F7_MUL:  o_dec_c.op = OP_MUL;
                    default: o_dec_c.illegal = 1'b1;
                endcase
            end
            default: o_dec_c.op = OP_ADD;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Registers decoded ALU ops for execute and sequences multi-cycle MULs,
// back-pressuring decode while a MUL occupies the ALU.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int unsigned ALU_OP_WIDTH = 2,
    parameter int unsigned MUL_LATENCY  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    alu_issue_ctrl_if.slave  bus
);

    localparam int unsigned CNT_WIDTH = $clog2(MUL_LATENCY + 1);

    state_t                  r_state;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [ALU_OP_WIDTH-1:0] r_alu_op;
    logic                    r_illegal;
    logic                    r_out_valid;
    logic                    r_mul_busy;

    dec_t w_dec;
    logic w_accept;
    logic w_is_mul;

    alu_op_decode u_decode (
        .i_func7 (bus.inst),
        .i_ctrl  (bus.ctrl_alu_op),
        .o_dec_c (w_dec)
    );

    assign bus.in_ready = (r_state == ST_IDLE) | ((r_state == ST_VALID) & bus.out_ready);
    assign w_accept     = bus.in_valid & bus.in_ready & ~flush;
    assign w_is_mul     = (w_dec.op == OP_MUL);

    // Counter loads only on a MUL accept and decrements toward 0; the MUL
    // completes the cycle after it reaches 0, giving MUL_LATENCY cycles total.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_alu_op    <= '0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
            r_mul_busy  <= 1'b0;
        end else if (flush) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
            r_mul_busy  <= 1'b0;
        end else begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_WIDTH'(1);
            end
            case (r_state)
                ST_IDLE, ST_VALID: begin
                    if (w_accept) begin
                        r_alu_op  <= ALU_OP_WIDTH'(w_dec.op);
                        r_illegal <= w_dec.illegal;
                        if (w_is_mul && (MUL_LATENCY > 1)) begin
                            r_state     <= ST_MUL_WAIT;
                            r_cnt       <= CNT_WIDTH'(MUL_LATENCY - 1);
                            r_mul_busy  <= 1'b1;
                            r_out_valid <= 1'b0;
                        end else begin
                            r_state     <= ST_VALID;
                            r_out_valid <= 1'b1;
                        end
                    end else if ((r_state == ST_VALID) && bus.out_ready) begin
                        r_state     <= ST_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_MUL_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_VALID;
                        r_out_valid <= 1'b1;
                        r_mul_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_out_valid <= 1'b0;
                    r_mul_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alu_op    = r_alu_op;
    assign bus.illegal   = r_illegal;
    assign bus.out_valid = r_out_valid;
    assign bus.mul_busy  = r_mul_busy;

endmodule
